ps2_rx_fifo_param: RTL and testbench
====================================

// Module: ps2_rx_fifo_param
// PURPOSE
//  Parametrised PS/2 device-to-host receiver; next generation of the FSM+shift-register receiver.
//  Synchronises ps2_c/ps2_d and detects falling edges internally; no external fall_edge needed.
//  Also checks framing/parity, has a watchdog timeout, and buffers received words in a FIFO with ready/valid pop.
//  Sits between the PS/2 pins and the keyboard/mouse decode logic; coexists with the host transmitter via tx_idle.
// PARAMETERS
//  DATA_W       8     data bits per frame (LSB first)
//  SYNC_STAGES  2     flip-flops in each pin synchroniser (>=2)
//  TIMEOUT_CYC  5000  clk cycles without a ps2_c falling edge before an in-progress frame is aborted
//  FIFO_DEPTH   4     received-word buffer entries (power of 2, >=2)
// PORTS
//  clk         in   1                      system clock
//  rst         in   1                      asynchronous reset, active-high
//  ps2_c       in   1                      PS/2 clock pin (raw, asynchronous)
//  ps2_d       in   1                      PS/2 data pin (raw, asynchronous)
//  tx_idle     in   1                      1 = host transmitter idle; 0 = receiver held/flushed to IDLE
//  rx_ready    in   1                      consumer pops FIFO head when rx_valid & rx_ready
//  rx_data     out  DATA_W                 FIFO head word
//  rx_valid    out  1                      FIFO non-empty
//  rx_count    out  $clog2(FIFO_DEPTH)+1   FIFO occupancy
//  rx_done     out  1                      1-cycle pulse: good frame accepted
//  frame_err   out  1                      1-cycle pulse: stop bit 0, or parity bad (macro on)
//  timeout_err out  1                      1-cycle pulse: watchdog aborted frame
//  overflow    out  1                      1-cycle pulse: good frame dropped, FIFO full
// BEHAVIOUR
//  Reset: FSM=IDLE, shift reg/bit counter/watchdog=0, FIFO empty; rx_data=0; all outputs 0.
//  Edge: fe = synced ps2_c previous 1 & current 0; ps2_d sampled from its synchroniser in the same cycle.
//  FSM (advances only on fe, except timeout/tx_idle):
//   IDLE   : fe & d=0 -> DATA (bit cnt=0); fe & d=1 -> stay IDLE (glitch, no error)
//   DATA   : fe -> shift d in at MSB (right shift, LSB first); cnt==DATA_W-1 -> PARITY
//   PARITY : fe -> latch d -> STOP
//   STOP   : fe -> IDLE; good = (d==1) & parity ok -> push, else frame_err
//  Parity: odd over DATA_W data bits + parity bit.
//  Latency: rx_done/push registered 1 cycle after the stop-bit fe cycle; rx_valid rises the next cycle if FIFO was empty.
//  Watchdog: counts clk cycles in non-IDLE states, cleared on every fe; reaching TIMEOUT_CYC -> IDLE, timeout_err, partial word discarded.
//  tx_idle=0: FSM forced to IDLE next cycle, partial word discarded, no error pulse; FIFO contents kept.
//  FIFO: push when good & (not full | pop same cycle); full & no pop -> word dropped, overflow pulse, rx_done still 0.
//   pop when rx_valid & rx_ready; pop on empty ignored; simultaneous push+pop: count unchanged.
//   pointers wrap modulo FIFO_DEPTH; rx_data = mem[rd_ptr], holds last value when empty.
//  Timeout and stop-bit fe in the same cycle: stop-bit handling wins (fe clears watchdog first).
//  Async rst mid-frame: everything to reset values immediately; FIFO contents lost.
// CONFIGURATION
//  PS2_RX_PARITY_CHK_EN defined: bad parity -> frame_err, word not pushed.
//  Undefined: parity bit sampled and ignored; only stop bit checked; frame_err only for stop=0.
// TESTING
//  1 frame 0x1C, odd parity 0, stop 1 -> rx_done 1 pulse, rx_valid=1, rx_data=8'h1C, rx_count=1.
//  2 0x1C with parity 1 -> macro on: frame_err, rx_count=0; macro off: rx_done, rx_data=8'h1C.
//  3 5 good frames 0x01..0x05, rx_ready=0 -> count=4, 5th gives overflow; pops yield 01,02,03,04.
//  4 start + 3 data bits, then ps2_c idle TIMEOUT_CYC cycles -> timeout_err; next frame 0xF0 received.
//  5 tx_idle=0 mid-frame then 1; frame 0xAA -> no error pulse, only 0xAA in FIFO.
//  6 rst asserted during DATA with 2 words queued -> outputs 0, rx_count=0 immediately.

Source files
------------

// File: rtl/ps2_rx_fifo_param.sv
// PS/2 device-to-host receiver with pin synchronisers, framing/parity check, watchdog and ready/valid FIFO.
// Optional macro PS2_RX_PARITY_CHK_EN: when defined, a bad odd-parity bit rejects the frame.
//
// state    | meaning
// IDLE     | waiting for a start bit (falling edge with data low)
// DATA     | shifting in DATA_W data bits, LSB first
// PARITY   | capturing the parity bit
// STOP     | checking the stop bit and deciding push / frame error
module ps2_rx_fifo_param #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 5000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_c,
  input  logic                          ps2_d,
  input  logic                          tx_idle,
  input  logic                          rx_ready,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_done,
  output logic                          frame_err,
  output logic                          timeout_err,
  output logic                          overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = $clog2(DATA_W + 1);
  localparam int WW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Synchronisers reset high so an idle bus never looks like a falling edge.
  logic [SYNC_STAGES-1:0] c_sync, d_sync;
  logic                   c_prev;
  logic                   c_s, d_s, fe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_sync <= '1;
      d_sync <= '1;
      c_prev <= 1'b1;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], ps2_c};
      d_sync <= {d_sync[SYNC_STAGES-2:0], ps2_d};
      c_prev <= c_sync[SYNC_STAGES-1];
    end
  end

  assign c_s = c_sync[SYNC_STAGES-1];
  assign d_s = d_sync[SYNC_STAGES-1];
  assign fe  = c_prev & ~c_s;

  state_t            state, state_n;
  logic [BCW-1:0]    cnt, cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [WW-1:0]     wd, wd_n;
  logic              good_n, ferr_n, tout_n, par_ok;
`ifdef PS2_RX_PARITY_CHK_EN
  logic              par, par_n;
  assign par_ok = ^{shreg, par};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    wd_n    = wd;
    good_n  = 1'b0;
    ferr_n  = 1'b0;
    tout_n  = 1'b0;
`ifdef PS2_RX_PARITY_CHK_EN
    par_n   = par;
`endif
    if (!tx_idle) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      shreg_n = '0;
      wd_n    = '0;
    end else if (state == S_IDLE) begin
      wd_n = '0;
      if (fe && !d_s) begin
        state_n = S_DATA;
        cnt_n   = '0;
        shreg_n = '0;
      end
    end else if (fe) begin
      // Stop-bit edge beats a coincident timeout because the edge is examined first.
      wd_n = '0;
      if (state == S_DATA) begin
        shreg_n = {d_s, shreg[DATA_W-1:1]};
        if (cnt == BCW'(DATA_W - 1)) state_n = S_PARITY;
        else                         cnt_n   = cnt + BCW'(1);
      end else if (state == S_PARITY) begin
`ifdef PS2_RX_PARITY_CHK_EN
        par_n   = d_s;
`endif
        state_n = S_STOP;
      end else begin
        state_n = S_IDLE;
        if (d_s && par_ok) good_n = 1'b1;
        else               ferr_n = 1'b1;
      end
    end else if (wd == WW'(TIMEOUT_CYC - 1)) begin
      state_n = S_IDLE;
      tout_n  = 1'b1;
      wd_n    = '0;
      cnt_n   = '0;
      shreg_n = '0;
    end else begin
      wd_n = wd + WW'(1);
    end
  end

  logic              good_q;
  logic [DATA_W-1:0] word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      wd          <= '0;
      good_q      <= 1'b0;
      word_q      <= '0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
`ifdef PS2_RX_PARITY_CHK_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= shreg_n;
      wd          <= wd_n;
      good_q      <= good_n;
      word_q      <= shreg;
      frame_err   <= ferr_n;
      timeout_err <= tout_n;
`ifdef PS2_RX_PARITY_CHK_EN
      par         <= par_n;
`endif
    end
  end

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] last_data;
  logic              full, push, pop;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign rx_valid = (count != '0);
  assign pop      = rx_valid & rx_ready;
  assign push     = good_q & (~full | pop);
  assign rx_done  = push;
  assign overflow = good_q & full & ~pop;
  assign rx_count = count;
  // After the last pop the head keeps showing the word just consumed.
  assign rx_data  = rx_valid ? mem[rd_ptr] : last_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_data <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= word_q;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        last_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo_param.sv
// Self-checking bench for ps2_rx_fifo_param: directed scenarios plus randomized frames against a queue model.
// Expectations follow PS2_RX_PARITY_CHK_EN when it is defined for the build.
module tb_ps2_rx_fifo_param;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int TOUT   = 300;
  localparam int HALF   = 8;
`ifdef PS2_RX_PARITY_CHK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic clk = 0, rst = 1, ps2_c = 1, ps2_d = 1, tx_idle = 1, rx_ready = 0;
  logic [DATA_W-1:0] rx_data;
  logic [$clog2(DEPTH):0] rx_count;
  logic rx_valid, rx_done, frame_err, timeout_err, overflow;

  int n_cmp = 0, n_err = 0;
  int c_done = 0, c_ferr = 0, c_tout = 0, c_ovf = 0;
  logic [DATA_W-1:0] q[$];

  ps2_rx_fifo_param #(.DATA_W(DATA_W), .SYNC_STAGES(2), .TIMEOUT_CYC(TOUT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ps2_c(ps2_c), .ps2_d(ps2_d), .tx_idle(tx_idle), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count), .rx_done(rx_done),
    .frame_err(frame_err), .timeout_err(timeout_err), .overflow(overflow));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_done)     c_done++;
      if (frame_err)   c_ferr++;
      if (timeout_err) c_tout++;
      if (overflow)    c_ovf++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_d = b;
    wait_cyc(HALF);
    ps2_c = 0;
    wait_cyc(HALF);
    ps2_c = 1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input bit par_flip, input bit stop_b);
    send_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
    send_bit((~^d) ^ par_flip);
    send_bit(stop_b);
    ps2_d = 1;
    wait_cyc(6);
  endtask

  task automatic do_pop();
    rx_ready = 1;
    wait_cyc(1);
    rx_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    wait_cyc(3);
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    n_cmp++; if (rx_count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", rx_count); end
    n_cmp++; if (rx_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 00", rx_data); end
    n_cmp++; if ({rx_done, frame_err, timeout_err, overflow} !== 4'b0) begin
      n_err++; $display("FAIL reset_pulses got %b want 0000", {rx_done, frame_err, timeout_err, overflow}); end
    rst = 0;
    wait_cyc(4);
  endtask

  task automatic test_single();
    int d0 = c_done;
    send_frame(8'h1C, 0, 1);
    n_cmp++; if (c_done - d0 !== 1) begin n_err++; $display("FAIL single_done got %0d want 1", c_done - d0); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", rx_valid); end
    n_cmp++; if (rx_data !== 8'h1C) begin n_err++; $display("FAIL single_data got %h want 1c", rx_data); end
    n_cmp++; if (rx_count !== 1) begin n_err++; $display("FAIL single_count got %0d want 1", rx_count); end
    do_pop();
    n_cmp++; if (rx_valid !== 1'b0 || rx_data !== 8'h1C) begin
      n_err++; $display("FAIL single_after_pop valid %b data %h want 0 1c", rx_valid, rx_data); end
  endtask

  task automatic test_parity();
    int d0 = c_done, f0 = c_ferr;
    send_frame(8'h1C, 1, 1);
    n_cmp++; if (c_ferr - f0 !== (PCHK ? 1 : 0)) begin
      n_err++; $display("FAIL parity_ferr got %0d want %0d", c_ferr - f0, PCHK ? 1 : 0); end
    n_cmp++; if (c_done - d0 !== (PCHK ? 0 : 1)) begin
      n_err++; $display("FAIL parity_done got %0d want %0d", c_done - d0, PCHK ? 0 : 1); end
    n_cmp++; if (rx_count !== (PCHK ? 0 : 1)) begin
      n_err++; $display("FAIL parity_count got %0d want %0d", rx_count, PCHK ? 0 : 1); end
    if (!PCHK) begin
      n_cmp++; if (rx_data !== 8'h1C) begin n_err++; $display("FAIL parity_data got %h want 1c", rx_data); end
      do_pop();
    end
    send_frame(8'h5A, 0, 0);
    n_cmp++; if (c_ferr - f0 !== (PCHK ? 2 : 1)) begin
      n_err++; $display("FAIL stop0_ferr got %0d want %0d", c_ferr - f0, PCHK ? 2 : 1); end
    n_cmp++; if (rx_count !== 0) begin n_err++; $display("FAIL stop0_count got %0d want 0", rx_count); end
  endtask

  task automatic test_overflow();
    int o0 = c_ovf, d0 = c_done;
    for (int i = 1; i <= 5; i++) send_frame(DATA_W'(i), 0, 1);
    n_cmp++; if (rx_count !== DEPTH) begin n_err++; $display("FAIL ovf_count got %0d want %0d", rx_count, DEPTH); end
    n_cmp++; if (c_ovf - o0 !== 1) begin n_err++; $display("FAIL ovf_pulse got %0d want 1", c_ovf - o0); end
    n_cmp++; if (c_done - d0 !== 4) begin n_err++; $display("FAIL ovf_done got %0d want 4", c_done - d0); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (rx_valid !== 1'b1 || rx_data !== DATA_W'(i)) begin
        n_err++; $display("FAIL ovf_pop%0d valid %b data %h want 1 %h", i, rx_valid, rx_data, DATA_W'(i)); end
      do_pop();
    end
    n_cmp++; if (rx_valid !== 1'b0 || rx_data !== 8'h04) begin
      n_err++; $display("FAIL ovf_empty valid %b data %h want 0 04", rx_valid, rx_data); end
    do_pop();
    n_cmp++; if (rx_count !== 0) begin n_err++; $display("FAIL pop_empty_count got %0d want 0", rx_count); end
  endtask

  task automatic test_timeout();
    int t0 = c_tout, f0 = c_ferr, d0 = c_done;
    send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    wait_cyc(TOUT - 40);
    n_cmp++; if (c_tout - t0 !== 0) begin n_err++; $display("FAIL tout_early got %0d want 0", c_tout - t0); end
    wait_cyc(60);
    n_cmp++; if (c_tout - t0 !== 1) begin n_err++; $display("FAIL tout_pulse got %0d want 1", c_tout - t0); end
    send_frame(8'hF0, 0, 1);
    n_cmp++; if (c_done - d0 !== 1 || c_ferr - f0 !== 0 || rx_data !== 8'hF0 || rx_count !== 1) begin
      n_err++; $display("FAIL tout_next done %0d ferr %0d data %h count %0d want 1 0 f0 1",
                        c_done - d0, c_ferr - f0, rx_data, rx_count); end
    do_pop();
  endtask

  task automatic test_tx_idle();
    int t0 = c_tout, f0 = c_ferr;
    send_bit(0); send_bit(1); send_bit(1);
    tx_idle = 0;
    wait_cyc(5);
    tx_idle = 1;
    wait_cyc(5);
    send_frame(8'hAA, 0, 1);
    n_cmp++; if (c_tout - t0 !== 0 || c_ferr - f0 !== 0) begin
      n_err++; $display("FAIL txidle_err tout %0d ferr %0d want 0 0", c_tout - t0, c_ferr - f0); end
    n_cmp++; if (rx_count !== 1 || rx_data !== 8'hAA) begin
      n_err++; $display("FAIL txidle_fifo count %0d data %h want 1 aa", rx_count, rx_data); end
    do_pop();
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      logic [DATA_W-1:0] d;
      bit pf, sb, good;
      int d0, f0, o0, ed, ef, eo, npop;
      d = DATA_W'($urandom);
      pf = ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 7) != 0);
      good = sb && !(pf && PCHK);
      ed = 0; ef = 0; eo = 0;
      if (!good) ef = 1;
      else if (q.size() < DEPTH) begin ed = 1; q.push_back(d); end
      else eo = 1;
      d0 = c_done; f0 = c_ferr; o0 = c_ovf;
      send_frame(d, pf, sb);
      n_cmp++; if (c_done - d0 !== ed || c_ferr - f0 !== ef || c_ovf - o0 !== eo || rx_count !== q.size()) begin
        n_err++; $display("FAIL rand%0d done %0d ferr %0d ovf %0d count %0d want %0d %0d %0d %0d",
                          k, c_done - d0, c_ferr - f0, c_ovf - o0, rx_count, ed, ef, eo, q.size()); end
      npop = $urandom_range(0, 2);
      for (int j = 0; j < npop; j++) begin
        if (q.size() > 0) begin
          n_cmp++; if (rx_valid !== 1'b1 || rx_data !== q[0]) begin
            n_err++; $display("FAIL rand_pop%0d valid %b data %h want 1 %h", k, rx_valid, rx_data, q[0]); end
          void'(q.pop_front());
        end
        do_pop();
      end
    end
    while (q.size() > 0) begin
      n_cmp++; if (rx_data !== q[0]) begin n_err++; $display("FAIL drain data %h want %h", rx_data, q[0]); end
      void'(q.pop_front());
      do_pop();
    end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got %b want 0", rx_valid); end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h11, 0, 1);
    send_frame(8'h22, 0, 1);
    send_bit(0); send_bit(1); send_bit(1);
    n_cmp++; if (rx_count !== 2) begin n_err++; $display("FAIL rstmid_pre count %0d want 2", rx_count); end
    #3 rst = 1;
    #1;
    n_cmp++; if (rx_count !== 0 || rx_valid !== 1'b0 || rx_data !== '0) begin
      n_err++; $display("FAIL rstmid count %0d valid %b data %h want 0 0 00", rx_count, rx_valid, rx_data); end
    n_cmp++; if ({rx_done, frame_err, timeout_err, overflow} !== 4'b0) begin
      n_err++; $display("FAIL rstmid_pulses got %b want 0000", {rx_done, frame_err, timeout_err, overflow}); end
    wait_cyc(3);
    rst = 0;
    wait_cyc(3);
    send_frame(8'h3C, 0, 1);
    n_cmp++; if (rx_count !== 1 || rx_data !== 8'h3C) begin
      n_err++; $display("FAIL rstmid_after count %0d data %h want 1 3c", rx_count, rx_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_overflow();
    test_timeout();
    test_tx_idle();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
